// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, palette codes and band/phase types.
// Latency: none (constants, types and a combinational palette lookup).
// Backpressure: none.
package vga_pkg;

    // Default 640x480@60 timing
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Sync pulse positions (inclusive) for the default timing
    localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC - 1;
    localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC - 1;

    localparam int DEF_BAND_H          = 160;
    localparam int DEF_FRAMES_PER_STEP = 60;

    // Palette codes as {r, g, b}
    localparam logic [2:0] COL_GREEN  = 3'b010;
    localparam logic [2:0] COL_YELLOW = 3'b110;
    localparam logic [2:0] COL_RED    = 3'b100;
    localparam logic [2:0] COL_WHITE  = 3'b111;
    localparam logic [2:0] COL_BLACK  = 3'b000;

    typedef logic [1:0] band_t;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2
    } phase_t;

    // Colour index 0..2 to palette code
    function automatic logic [2:0] palette(input logic [1:0] idx);
        case (idx)
            2'd0:    palette = COL_GREEN;
            2'd1:    palette = COL_YELLOW;
            2'd2:    palette = COL_RED;
            default: palette = COL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Horizontal/vertical raster counters with active-area, sync and frame-end decode.
// Latency: decode outputs are combinational from the current counter values.
// Backpressure: counters advance only on pix_en_i, otherwise hold.
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en_i,
    output logic [9:0] h_o,
    output logic [9:0] v_o,
    output logic       frame_end_o,
    output logic       pixel_on_o,
    output logic       hsync_n_o,
    output logic       vsync_n_o
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       h_last, v_last;

    assign h_last = (h_q == 10'(H_TOTAL - 1));
    assign v_last = (v_q == 10'(V_TOTAL - 1));

    // Next raster position: h wraps into a v increment, v wraps at frame end
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_en_i) begin
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_o         = h_q;
    assign v_o         = v_q;
    assign frame_end_o = h_last && v_last;
    assign pixel_on_o  = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
    assign hsync_n_o   = !((h_q >= 10'(HS_START)) && (h_q <= 10'(HS_END)));
    assign vsync_n_o   = !((v_q >= 10'(VS_START)) && (v_q <= 10'(VS_END)));

endmodule

// File: rtl/vga_band_scheduler.sv
// VGA timing plus three-band colour painter whose colours rotate every FRAMES_PER_STEP frames.
// Latency: one pix_en from raster counter to all outputs (x/y/syncs/rgb/phase aligned).
// Backpressure: every register holds while pix_en is low. Build option BAND_BORDER_EN paints band boundary rows white.
module vga_band_scheduler
    import vga_pkg::*;
#(
    parameter int H_ACTIVE        = DEF_H_ACTIVE,
    parameter int H_FP            = DEF_H_FP,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BP            = DEF_H_BP,
    parameter int V_ACTIVE        = DEF_V_ACTIVE,
    parameter int V_FP            = DEF_V_FP,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BP            = DEF_V_BP,
    parameter int BAND_H          = DEF_BAND_H,
    parameter int FRAMES_PER_STEP = DEF_FRAMES_PER_STEP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    input  logic       enable,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pixel_on,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       frame_start,
    output logic       red_out,
    output logic       green_out,
    output logic       blue_out,
    output logic [1:0] phase
);

    localparam int              CNT_W    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

    logic [9:0] h, v;
    logic       frame_end, on_c, hs_c, vs_c;

    vga_timing_counter #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en_i    (pix_en),
        .h_o         (h),
        .v_o         (v),
        .frame_end_o (frame_end),
        .pixel_on_o  (on_c),
        .hsync_n_o   (hs_c),
        .vsync_n_o   (vs_c)
    );

    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    band_t            band;
    logic [2:0]       sum;
    logic [1:0]       cidx;
    logic [2:0]       rgb_d, rgb_q;

    // Band, rotated colour index and blanking-gated colour for the current pixel
    always_comb begin
        if (v < 10'(BAND_H))          band = 2'd0;
        else if (v < 10'(2 * BAND_H)) band = 2'd1;
        else                          band = 2'd2;
        sum   = {1'b0, band} + {1'b0, phase_q};
        cidx  = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
        rgb_d = palette(cidx);
`ifdef BAND_BORDER_EN
        if ((v == 10'(BAND_H)) || (v == 10'(2 * BAND_H))) rgb_d = COL_WHITE;
`endif
        if (!on_c) rgb_d = COL_BLACK;
    end

    // Rotation: count enabled frame ends, step phase when the count wraps
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (pix_en && frame_end && enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                case (phase_q)
                    PH0:     phase_d = PH1;
                    PH1:     phase_d = PH2;
                    default: phase_d = PH0;
                endcase
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Rotation state registers; updated at frame end so the new phase starts at pixel (0,0)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH0;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output stage: everything registered together from the same raster position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            pixel_on    <= 1'b0;
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            frame_start <= 1'b0;
            rgb_q       <= COL_BLACK;
            phase       <= 2'd0;
        end else if (pix_en) begin
            x           <= h;
            y           <= v;
            pixel_on    <= on_c;
            hsync_n     <= hs_c;
            vsync_n     <= vs_c;
            frame_start <= (h == 10'd0) && (v == 10'd0);
            rgb_q       <= rgb_d;
            phase       <= phase_q;
        end
    end

    assign red_out   = rgb_q[2];
    assign green_out = rgb_q[1];
    assign blue_out  = rgb_q[0];

endmodule

// File: doc/vga_band_scheduler.md
Name: vga_band_scheduler

Overview:
- Generates 640x480@60 VGA timing (x, y, pixel_on, syncs) from a pixel-rate strobe.
- Drives the three-band colour datapath: screen is split into three horizontal bands, each painted one of green/yellow/red.
- Rotates the band-to-colour assignment every FRAMES_PER_STEP frames.
- Sits between the clock/strobe generator and the VGA DAC pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- BAND_H, 160, band height in lines
- FRAMES_PER_STEP, 60, frames between colour rotations (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  one-clk pixel strobe; all state advances only when high
- enable  in  1  rotation enable; timing runs regardless
- x  out  10  current pixel column
- y  out  10  current line
- pixel_on  out  1  high inside active area
- hsync_n  out  1  active-low hsync
- vsync_n  out  1  active-low vsync
- frame_start  out  1  high while outputs present pixel (0,0)
- red_out, green_out, blue_out  out  1 each  pixel colour
- phase  out  2  current rotation phase, 0..2

Behaviour:
- Reset (async, rst_n=0): h/v counters=0, frame counter=0, phase=0; x=0, y=0, pixel_on=0, hsync_n=1, vsync_n=1, frame_start=0, rgb=000. Release takes effect on the next clk edge; reset asserted mid-frame aborts immediately.
- pix_en=0: every register holds.
- Stage 0 (counters): h counts 0..H_TOTAL-1 (800) and wraps to 0, then increments v. v counts 0..V_TOTAL-1 (525) and wraps to 0.
- Stage 1: all outputs are registered together from stage-0 values, giving latency of one pix_en from counter to pins. x/y/syncs/rgb are mutually aligned.
- pixel_on = (h<H_ACTIVE) && (v<V_ACTIVE).
- hsync_n=0 for h in [656,751]; vsync_n=0 for v in [490,491].
- band = 0 for v<BAND_H, 1 for v<2*BAND_H, else 2.
- colour index = (band+phase) mod 3. Palette: 0 green (010), 1 yellow (110), 2 red (100).
- rgb=000 whenever pixel_on=0.
- Frame end is the pix_en where h=799 and v=524.
  - If enable=1, the frame counter increments.
  - When the counter equals FRAMES_PER_STEP-1 at frame end, it clears and phase increments (2 wraps to 0).
  - The new phase applies from pixel (0,0) of the next frame, never mid-frame.
- enable=0: frame counter and phase hold. Re-enabling resumes the count from the held value.
- enable toggling during frame end: the value sampled on that pix_en decides.
- x/y are meaningful in blanking (raw counters); consumers gate with pixel_on.

Optional Feature:
- Macro BAND_BORDER_EN.
- Defined: rows v==BAND_H and v==2*BAND_H, when active, output white (111) instead of the band colour.
- Undefined: no border; those rows take the normal band colour.
- Timing is identical in both builds.

Decomposition:
- Package vga_pkg holds:
  - timing constants and H_TOTAL/V_TOTAL derivations
  - sync start/end positions
  - palette codes (COL_GREEN, COL_YELLOW, COL_RED, COL_WHITE, COL_BLACK) as 3-bit constants
  - band_t 2-bit typedef
- Sub-module vga_timing_counter: h/v counters, frame-end pulse, pixel_on/sync decode.
- Top level: band decode, rotation FSM/counter, output register stage.

Test Plan:
- Reset asserted mid-line with pix_en=1 every clk -> all outputs immediately at reset values. After release, first pix_en gives h=0,v=0 and the following pix_en shows x=0, y=0, pixel_on=1, frame_start=1.
- Free-run one line -> hsync_n low for exactly 96 pixel strobes, starting when x=656. pixel_on low from x=640 to 799.
- Free-run one frame -> vsync_n low exactly on lines 490 and 491. Frame period = 420000 strobes.
- Phase 0, enable=1 -> x=100 gives rgb 010 at y=0, 110 at y=160, 100 at y=320, 000 at y=479 with x=700.
- FRAMES_PER_STEP=2, enable=1 -> phase 0,0,1,1,2,2,0 over frames 0..6. Frame 2 at y=0 shows yellow (110).
- enable=0 held for 5 frames then re-enabled (FRAMES_PER_STEP=2) -> phase unchanged during hold, then advances after the remaining frame count. With BAND_BORDER_EN, y=160 shows 111 and y=161 shows band colour.
